// File: rtl/irrigation_countdown_timer.sv
// irrigation_countdown_timer
//
// BCD mm:ss countdown for one irrigation cycle. Every reset reloads a preset
// duration (sprinkler or drip mode). The timer then counts down one second
// per tick while enabled, and stops in DONE at 00:00.
//
// Optional feature macro: TIMER_TICK_DIVIDER_EN
//   defined   : an internal prescaler of CLOCKS_PER_SECOND clocks produces the
//               tick and second_tick is ignored
//   undefined : second_tick is used directly as the tick
//
// Ports
//   clock            in   system clock; all state changes on its rising edge
//   reset            in   synchronous, active-high; reloads the preset
//   splinker_mode_on in   1 = sprinkler preset, 0 = drip preset (read in reset)
//   count_enable     in   1 = count on ticks, 0 = pause and hold
//   second_tick      in   one-clock 1 Hz strobe
//   minutes_d        out  minutes tens digit, 0..3
//   minutes_u        out  minutes units digit, 0..9
//   seconds_d        out  seconds tens digit, 0..5
//   seconds_u        out  seconds units digit, 0..9
//   running          out  1 while in RUN
//   done             out  1 while in DONE (00:00 reached)
module irrigation_countdown_timer #(
  parameter int SPRINKLER_PRESET_MIN = 10,
  parameter int DRIP_PRESET_MIN      = 30,
  parameter int CLOCKS_PER_SECOND    = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       splinker_mode_on,
  input  logic       count_enable,
  input  logic       second_tick,
  output logic [1:0] minutes_d,
  output logic [3:0] minutes_u,
  output logic [2:0] seconds_d,
  output logic [3:0] seconds_u,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SPR_MD  = 2'(SPRINKLER_PRESET_MIN / 10);
  localparam logic [3:0] SPR_MU  = 4'(SPRINKLER_PRESET_MIN % 10);
  localparam logic [1:0] DRIP_MD = 2'(DRIP_PRESET_MIN / 10);
  localparam logic [3:0] DRIP_MU = 4'(DRIP_PRESET_MIN % 10);

  // One-second BCD decrement with a full borrow chain. Callers never pass
  // 00:00, so the minutes tens digit cannot wrap.
  function automatic logic [12:0] dec_mmss(input logic [12:0] t);
    logic [1:0] md;
    logic [3:0] mu;
    logic [2:0] sd;
    logic [3:0] su;
    {md, mu, sd, su} = t;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (sd != 3'd0) begin
        sd = sd - 3'd1;
      end else begin
        sd = 3'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          md = md - 2'd1;
        end
      end
    end
    return {md, mu, sd, su};
  endfunction

  state_t      state;
  logic        tick;
  logic [12:0] cur_time;
  logic [12:0] nxt_time;

  assign cur_time = {minutes_d, minutes_u, seconds_d, seconds_u};

  always_comb begin
    nxt_time = dec_mmss(cur_time);
  end

`ifdef TIMER_TICK_DIVIDER_EN
  localparam int PS_W = (CLOCKS_PER_SECOND > 1) ? $clog2(CLOCKS_PER_SECOND) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLOCKS_PER_SECOND - 1);

  logic [PS_W-1:0] ps_cnt;

  assign tick = (ps_cnt == PS_LAST);

  // Prescaler advances only on edges where RUN actually counts, so it holds
  // across PAUSE and resumes mid-second.
  always_ff @(posedge clock) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (state == RUN && count_enable) begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
    end
  end
`else
  assign tick = second_tick;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      running   <= 1'b0;
      done      <= 1'b0;
      minutes_d <= splinker_mode_on ? SPR_MD : DRIP_MD;
      minutes_u <= splinker_mode_on ? SPR_MU : DRIP_MU;
      seconds_d <= 3'd0;
      seconds_u <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (count_enable) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          // Dropping enable wins over a coincident tick.
          if (!count_enable) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            {minutes_d, minutes_u, seconds_d, seconds_u} <= nxt_time;
            if (nxt_time == 13'd0) begin
              state   <= DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (count_enable) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/irrigation_countdown_timer.md
Name: irrigation_countdown_timer

Overview:
BCD mm:ss countdown timer for one irrigation cycle.
- On every reset it reloads a preset duration chosen by sprinkler/drip mode.
- It counts down one second per tick while enabled and exposes its digits to the downstream timer reset logic.
- The minutes_d / minutes_u / seconds_d digit outputs are the exact widths that logic consumes.

Parameters:
- SPRINKLER_PRESET_MIN, 10, preset minutes when splinker_mode_on=1; legal range 1..39.
- DRIP_PRESET_MIN, 30, preset minutes when splinker_mode_on=0; legal range 1..39.
- CLOCKS_PER_SECOND, 50_000_000, prescaler terminal count; used only with TIMER_TICK_DIVIDER_EN.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; reloads preset.
- splinker_mode_on  input  1  1 = sprinkler preset, 0 = drip preset; sampled only while reset=1.
- count_enable  input  1  1 = count down on ticks, 0 = pause and hold.
- second_tick  input  1  one-clock-wide 1 Hz strobe; ignored when TIMER_TICK_DIVIDER_EN is defined.
- minutes_d  output  2  minutes tens digit, 0..3.
- minutes_u  output  4  minutes units digit, BCD 0..9.
- seconds_d  output  3  seconds tens digit, 0..5.
- seconds_u  output  4  seconds units digit, BCD 0..9.
- running  output  1  1 while in RUN state.
- done  output  1  1 while in DONE state (00:00 reached).

Behaviour:
- Reset (reset=1 at clock edge):
  - Digits load PRESET:00. PRESET = SPRINKLER_PRESET_MIN if splinker_mode_on else DRIP_PRESET_MIN.
  - minutes_d = PRESET/10, minutes_u = PRESET%10, seconds_d = 0, seconds_u = 0.
  - State = IDLE; running = 0; done = 0; prescaler cleared.
  - Reset has priority over every other input, including mid-RUN and in DONE.
- States:
  - IDLE: digits hold. count_enable=1 -> RUN on the next edge. No decrement on the entry edge.
  - RUN: on each edge with tick=1, the digits decrement by one second.
    - count_enable=0 -> PAUSE; a tick on that same edge is ignored.
    - When the decrement result is 00:00 -> DONE on the same edge.
  - PAUSE: digits hold. count_enable=1 -> RUN.
  - DONE: digits hold at 00:00; done = 1. Exit only via reset.
- Decrement, all in one cycle, with borrow chain:
  - seconds_u: 0 -> 9 with borrow; otherwise -1.
  - seconds_d on borrow: 0 -> 5 with borrow; otherwise -1.
  - minutes_u on borrow: 0 -> 9 with borrow; otherwise -1.
  - minutes_d on borrow: -1. Never underflows, because DONE is entered at 00:00.
- Outputs are registered and update on the edge after the tick. Latency from tick to new digits is 1 clock.
- running and done are decoded from registered state; both are never 1 at once.
- Digits never take illegal BCD or out-of-range values, in any state.
- splinker_mode_on changes outside reset have no effect until the next reset.

Optional Feature:
- Macro TIMER_TICK_DIVIDER_EN.
- Defined:
  - Internal counter counts clocks while in RUN.
  - It generates a one-clock tick when it reaches CLOCKS_PER_SECOND-1, then wraps to 0.
  - The counter holds its value in PAUSE and clears on reset.
  - second_tick is ignored.
- Undefined: no prescaler is built; second_tick is used directly as the tick.

Test Plan:
- Reset with splinker_mode_on=1, SPRINKLER_PRESET_MIN=10 -> digits 1,0,0,0; running=0; done=0.
- Reset with splinker_mode_on=0, DRIP_PRESET_MIN=30, then count_enable=1 and one tick -> 29:59; running=1.
- Preset 1 minute, 60 ticks -> 00:00 after the 60th tick edge; done=1; further ticks leave digits at 00:00.
- Count from 10:00 to 09:30, drop count_enable for 20 ticks -> digits hold 09:30; re-enable with 1 tick -> 09:29.
- Reset asserted mid-RUN at 05:17 in drip mode -> next edge digits 30:00, IDLE; a tick coincident with reset is ignored.
- TIMER_TICK_DIVIDER_EN with CLOCKS_PER_SECOND=4, RUN from 01:00 -> first decrement after 4 clocks, then every 4 clocks; second_tick pulses have no effect.
